// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp aspect encodings, guard states and fault-cause bit positions.
package traffic_pkg;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] GREEN = 3'b001;
    localparam logic [2:0] DARK  = 3'b000;
    typedef enum logic [1:0] {ALL_RED, NORMAL, FAULT} guard_state_e;
    localparam int FC_ENC = 0;
    localparam int FC_S   = 1;
    localparam int FC_MT  = 2;
    function automatic logic is_aspect(input logic [2:0] v);
        return v == RED || v == AMBER || v == GREEN;
    endfunction
endpackage

// File: rtl/traffic_conflict_check.sv
// traffic_conflict_check: combinational encoding and conflicting-green cause detection.
module traffic_conflict_check
    import traffic_pkg::*;
(
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    output logic [2:0] cause
);
    assign cause[FC_ENC] = !(is_aspect(light_M1) && is_aspect(light_M2) && is_aspect(light_MT) && is_aspect(light_S));
    assign cause[FC_S]   = light_S != RED && (light_M1 != RED || light_M2 != RED || light_MT != RED);
    assign cause[FC_MT]  = light_MT != RED && light_M2 != RED;
endmodule

// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard: filtered conflict guard with fault flashing and all-red recovery; LAMP_DIM_EN adds PWM dimming.
module traffic_lamp_guard
    import traffic_pkg::*;
#(
    parameter int FILTER_CYC     = 4,
    parameter int FLASH_HALF_CYC = 25_000_000,
    parameter int ALL_RED_CYC    = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
`ifdef LAMP_DIM_EN
    input  logic       dim,
`endif
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam int VW = $clog2(FILTER_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF_CYC + 1);
    localparam int AW = $clog2(ALL_RED_CYC + 1);
    localparam logic [VW-1:0] V_MAX  = VW'(FILTER_CYC);
    localparam logic [FW-1:0] F_LAST = FW'(FLASH_HALF_CYC - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALL_RED_CYC - 1);

    guard_state_e  state_q, state_d;
    logic [VW-1:0] viol_cnt_q, viol_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [AW-1:0] red_cnt_q, red_cnt_d;
    logic          phase_q, phase_d;
    logic [2:0]    cause, cause_acc_q, cause_acc_d, fault_code_q, fault_code_d;
    logic [11:0]   lamp_q, lamp_d, lamp_raw, lamp, light;
    logic          viol, trip;

    assign light = {light_M1, light_M2, light_MT, light_S};

    traffic_conflict_check u_check (
        .light_M1(light_M1),
        .light_M2(light_M2),
        .light_MT(light_MT),
        .light_S (light_S),
        .cause   (cause)
    );

    assign viol = |cause;

    always_comb begin
        viol_cnt_d   = !viol ? '0 : viol_cnt_q == V_MAX ? V_MAX : viol_cnt_q + 1'b1;
        cause_acc_d  = viol ? cause_acc_q | cause : '0;
        trip         = state_q != FAULT && viol_cnt_d == V_MAX;
        state_d      = state_q;
        fault_code_d = fault_code_q;
        if (trip) begin
            state_d      = FAULT;
            fault_code_d = fault_code_q | cause_acc_d;
        end else if (state_q == ALL_RED && red_cnt_q == A_LAST) begin
            state_d = NORMAL;
        end else if (state_q == FAULT && fault_clr && !viol) begin
            state_d      = ALL_RED;
            fault_code_d = '0;
        end
        red_cnt_d   = state_q != ALL_RED ? '0 : red_cnt_q == A_LAST ? red_cnt_q : red_cnt_q + 1'b1;
        flash_cnt_d = state_q != FAULT || flash_cnt_q == F_LAST ? '0 : flash_cnt_q + 1'b1;
        phase_d     = state_q != FAULT ? 1'b1 : flash_cnt_q == F_LAST ? !phase_q : phase_q;
        // A violating cycle never reaches the lamps; the last clean aspect is held instead.
        lamp_d      = state_d == NORMAL ? (viol ? lamp_q : light) : {4{RED}};
        lamp_raw    = state_q == FAULT ? {4{phase_q ? AMBER : DARK}} : lamp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ALL_RED;
            viol_cnt_q   <= '0;
            flash_cnt_q  <= '0;
            red_cnt_q    <= '0;
            phase_q      <= 1'b1;
            cause_acc_q  <= '0;
            fault_code_q <= '0;
            lamp_q       <= {4{RED}};
        end else begin
            state_q      <= state_d;
            viol_cnt_q   <= viol_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            red_cnt_q    <= red_cnt_d;
            phase_q      <= phase_d;
            cause_acc_q  <= cause_acc_d;
            fault_code_q <= fault_code_d;
            lamp_q       <= lamp_d;
        end
    end

`ifdef LAMP_DIM_EN
    logic [7:0] pwm_q;
    always_ff @(posedge clk) begin
        pwm_q <= rst ? '0 : pwm_q + 1'b1;
    end
    assign lamp = lamp_raw & {12{!dim || pwm_q < 8'd64}};
`else
    assign lamp = lamp_raw;
`endif

    assign {lamp_M1, lamp_M2, lamp_MT, lamp_S} = lamp;
    assign fault      = state_q == FAULT;
    assign fault_code = fault_code_q;
endmodule

// File: tb/tb_traffic_lamp_guard.sv
// tb_traffic_lamp_guard: directed scenarios plus randomized segments against a behavioural lamp-guard model.
module tb_traffic_lamp_guard;
    localparam logic [2:0] R = 3'b100, A = 3'b010, G = 3'b001;

    logic clk = 1'b0, rst = 1'b1, fault_clr = 1'b0, dim = 1'b0;
    logic [2:0] m1 = R, m2 = R, mt = R, s = R;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S, fault_code;
    logic fault;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    traffic_lamp_guard #(.FILTER_CYC(4), .FLASH_HALF_CYC(3), .ALL_RED_CYC(5)) dut (
        .clk(clk), .rst(rst),
        .light_M1(m1), .light_M2(m2), .light_MT(mt), .light_S(s),
        .fault_clr(fault_clr),
`ifdef LAMP_DIM_EN
        .dim(dim),
`endif
        .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
        .fault(fault), .fault_code(fault_code)
    );

    task automatic chk(input string n, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] causes(input logic [11:0] v);
        logic [2:0] c;
        logic [2:0] a [4];
        a[0] = v[11:9]; a[1] = v[8:6]; a[2] = v[5:3]; a[3] = v[2:0];
        c = '0;
        for (int i = 0; i < 4; i++) if ($countones(a[i]) != 1) c[0] = 1'b1;
        if (a[3] != R && (a[0] != R || a[1] != R || a[2] != R)) c[1] = 1'b1;
        if (a[2] != R && a[1] != R) c[2] = 1'b1;
        return c;
    endfunction

    // mode: 0 all-red hold, 1 pass-through, 2 fault; age counts cycles spent in the mode
    int mode = 0, age = 0, run = 0, pwm = 0;
    logic [2:0] runc = '0, code = '0;
    logic [11:0] held = {4{R}};
    logic armed = 1'b0;

    always @(posedge clk) begin : model
        logic [11:0] in;
        logic [2:0] c;
        in = {m1, m2, mt, s};
        c = causes(in);
        if (rst) begin
            armed = 1'b1; mode = 0; age = 0; run = 0; runc = '0; code = '0; held = {4{R}}; pwm = 0;
        end else begin
            pwm  = (pwm + 1) % 256;
            run  = c != 0 ? run + 1 : 0;
            runc = c != 0 ? runc | c : '0;
            if (mode != 2 && run >= 4) begin
                mode = 2; age = 0; code = code | runc;
            end else if (mode == 0) begin
                if (age == 4) begin
                    mode = 1;
                    if (c == 0) held = in;
                end else age++;
            end else if (mode == 1) begin
                if (c == 0) held = in;
            end else if (fault_clr && c == 0) begin
                mode = 0; age = 0; code = '0; held = {4{R}};
            end else age++;
        end
    end

    always @(negedge clk) begin : compare
        logic [11:0] exp;
        if (armed) begin
            exp = mode == 2 ? (((age / 3) % 2 == 0) ? {4{A}} : 12'h000) : held;
`ifdef LAMP_DIM_EN
            if (dim && pwm >= 64) exp = '0;
`endif
            chk("model_lamps", {lamp_M1, lamp_M2, lamp_MT, lamp_S}, exp);
            chk("model_fault", {11'd0, fault}, {11'd0, mode == 2});
            chk("model_code", {9'd0, fault_code}, {9'd0, code});
        end
    end

    function automatic logic [11:0] lamps();
        return {lamp_M1, lamp_M2, lamp_MT, lamp_S};
    endfunction

    logic [11:0] ph [6];
    logic [11:0] vec;

    initial begin
        ph[0] = {G, G, R, R}; ph[1] = {A, A, R, R}; ph[2] = {G, R, G, R};
        ph[3] = {A, R, A, R}; ph[4] = {R, R, R, G}; ph[5] = {R, R, R, A};
        {m1, m2, mt, s} = {G, G, R, R};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_hold", lamps(), {4{R}});
        end
        @(negedge clk);
        chk("t1_pass", lamps(), {G, G, R, R});
        chk("t1_fault", {11'd0, fault}, 12'd0);
        for (int p = 0; p < 6; p++) begin
            {m1, m2, mt, s} = ph[p];
            @(negedge clk);
            chk("t2_phase", lamps(), ph[p]);
            @(negedge clk);
        end
        {m1, m2, mt, s} = {G, G, R, R};
        repeat (2) @(negedge clk);
        {m1, m2, mt, s} = {G, R, R, G};
        repeat (3) begin
            @(negedge clk);
            chk("t3_hold", lamps(), {G, G, R, R});
        end
        {m1, m2, mt, s} = {R, R, R, G};
        @(negedge clk);
        chk("t3_clean", lamps(), {R, R, R, G});
        chk("t3_fault", {11'd0, fault}, 12'd0);
        {m1, m2, mt, s} = {G, R, R, G};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_flash", lamps(), i < 3 ? {4{A}} : 12'h000);
            if (i == 0) begin
                chk("t4_fault", {11'd0, fault}, 12'd1);
                chk("t4_code", {9'd0, fault_code}, 12'b010);
            end
        end
        {m1, m2, mt, s} = {R, G, G, R};
        fault_clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_ignored", {11'd0, fault}, 12'd1);
        {m1, m2, mt, s} = {R, R, R, R};
        @(negedge clk);
        chk("t5_cleared", {11'd0, fault}, 12'd0);
        chk("t5_code", {9'd0, fault_code}, 12'd0);
        chk("t5_red", lamps(), {4{R}});
        fault_clr = 1'b0;
        {m1, m2, mt, s} = {G, G, R, R};
        repeat (4) begin
            @(negedge clk);
            chk("t5_red", lamps(), {4{R}});
        end
        @(negedge clk);
        chk("t5_normal", lamps(), {G, G, R, R});
        rst = 1'b1;
        {m1, m2, mt, s} = {R, R, R, R};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        {m1, m2, mt, s} = {R, 3'b011, R, R};
        repeat (3) @(negedge clk);
        chk("t6_still_red", lamps(), {4{R}});
        @(negedge clk);
        chk("t6_fault", {11'd0, fault}, 12'd1);
        chk("t6_code", {9'd0, fault_code}, 12'b001);
        chk("t6_amber", lamps(), {4{A}});
        {m1, m2, mt, s} = {R, R, R, R};
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = $urandom_range(0, 49) == 0;
            vec = $urandom_range(0, 4) < 3 ? ph[$urandom_range(0, 5)] : 12'($urandom);
            {m1, m2, mt, s} = vec;
            fault_clr = $urandom_range(0, 3) == 0;
            dim = $urandom_range(0, 1) == 1;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
